// File: rtl/uart_ram_loader_if.sv
// RAM write-port bundle driven by the UART program loader.
// The loader is the master; the RAM-side mux is the slave.
interface uart_ram_loader_if;
    logic        ram_w_en;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;

    modport master (
        output ram_w_en,
        output ram_addr,
        output ram_wdata
    );

    modport slave (
        input ram_w_en,
        input ram_addr,
        input ram_wdata
    );
endinterface

// File: rtl/uart_ram_loader.sv
// UART program loader: assembles big-endian byte pairs into
// 16-bit words and writes them to RAM while holding the core.
module uart_ram_loader #(
    parameter int CLKS_PER_BIT = 104,
    parameter int WORD_COUNT   = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx,
    input  logic                load_start,
    uart_ram_loader_if.master   ram,
    output logic                cpu_hold,
    output logic                busy,
    output logic                done,
    output logic                frame_error,
    output logic [8:0]          words_written
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [8:0]    LAST = 9'(WORD_COUNT - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } ld_state_t;

    logic          rx_s1, rx_s2, rx_d;
    logic          rx_fall;
    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_vld_q, byte_vld_d;
    logic          ferr_q, ferr_d;

    ld_state_t     state_q, state_d;
    logic          start_load;
    logic          phase_hi;

    // rx_d holds the previous synchronized level for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign rx_fall = rx_d & ~rx_s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            byte_vld_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            byte_vld_q <= byte_vld_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_vld_d = 1'b0;
        ferr_d     = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_fall)
                    rx_state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF) begin
                    cnt_d      = '0;
                    bit_d      = '0;
                    rx_state_d = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_s2, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7)
                        rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d      = '0;
                    rx_state_d = RX_IDLE;
                    byte_vld_d = rx_s2;
                    ferr_d     = ~rx_s2;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Leave LOAD right after the final strobe so the core is
    // released on the cycle following the last RAM write.
    always_comb begin
        state_d    = state_q;
        start_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    start_load = 1'b1;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (ram.ram_w_en && words_written == LAST)
                    state_d = DONE;
            end
            DONE: begin
                if (load_start) begin
                    start_load = 1'b1;
                    state_d    = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram.ram_w_en  <= 1'b0;
            ram.ram_addr  <= '0;
            ram.ram_wdata <= '0;
            words_written <= '0;
            frame_error   <= 1'b0;
            phase_hi      <= 1'b1;
        end else begin
            ram.ram_w_en <= 1'b0;
            if (ram.ram_w_en)
                words_written <= words_written + 9'd1;
            if (start_load) begin
                words_written <= '0;
                ram.ram_addr  <= '0;
                frame_error   <= 1'b0;
                phase_hi      <= 1'b1;
            end else begin
                if (ferr_q) begin
                    frame_error <= 1'b1;
                    phase_hi    <= 1'b1;
                end
                if (state_q == LOAD && byte_vld_q) begin
                    if (phase_hi) begin
                        ram.ram_wdata[15:8] <= shift_q;
                        phase_hi            <= 1'b0;
                    end else begin
                        ram.ram_wdata[7:0] <= shift_q;
                        ram.ram_addr       <= words_written[7:0];
                        ram.ram_w_en       <= 1'b1;
                        phase_hi           <= 1'b1;
                    end
                end
            end
        end
    end

    assign busy     = (state_q == LOAD);
    assign cpu_hold = busy;
    assign done     = (state_q == DONE);

endmodule

// File: doc/uart_ram_loader.md
# uart_ram_loader

Program loader that sits upstream of the FPG8 main memory and receives a program image over a UART serial line. It assembles the incoming bytes into 16-bit words and writes them into the 256×16 RAM at sequential addresses. It holds the processor core in reset until the full image has been written. Its write port is muxed onto the RAM `w_en`/`addr`/data lines whenever `cpu_hold` is high.

## Interface
- `CLKS_PER_BIT`, 104, clock cycles per UART bit; 104 gives 115200 baud at 12 MHz. Must be ≥ 4.
- `WORD_COUNT`, 256, number of 16-bit words per image; range 1..256.
- `clk`  in  1  system clock; the same clock as the core.
- `reset`  in  1  asynchronous, active-low reset.
- `rx`  in  1  UART receive line; asynchronous, idle high.
- `load_start`  in  1  single-cycle pulse that begins a load.
- `ram_w_en`  out  1  RAM write strobe, one cycle per word.
- `ram_addr`  out  8  RAM write address.
- `ram_wdata`  out  16  RAM write data.
- `cpu_hold`  out  1  high while loading; ORed into the core reset.
- `busy`  out  1  high in LOAD.
- `done`  out  1  high in DONE.
- `frame_error`  out  1  sticky bad-stop-bit flag.
- `words_written`  out  9  words written in the current load.

## Operation
- **rx synchronizer:** `rx` passes through a 2-flop synchronizer. The synchronizer resets to 1.
- **Receiver FSM:**
  - RX_IDLE → RX_START on a synchronized 1→0 edge.
  - RX_START: the line is sampled at count `CLKS_PER_BIT/2` (integer division). If the line is high, this is a false start and the FSM returns to RX_IDLE. If it is low, the FSM goes to RX_DATA.
  - RX_DATA: 8 samples, spaced `CLKS_PER_BIT`, LSB first.
  - RX_STOP: one sample, spaced `CLKS_PER_BIT`. If the stop bit is 1, the byte is valid. If it is 0, the byte is discarded, `frame_error` is set, and the byte phase resets to high. The FSM then returns to RX_IDLE.
- **Loader FSM:**
  - IDLE → LOAD on `load_start`. Entering LOAD sets `words_written` to 0, sets the byte phase to high, and clears `frame_error`.
  - In LOAD, the first valid byte of each pair is latched as `ram_wdata[15:8]`. The second valid byte is placed in `ram_wdata[7:0]` and triggers a write. Byte order is big-endian.
  - Write: `ram_w_en` is 1 for exactly one cycle, with `ram_addr = words_written[7:0]`. `words_written` increments at the end of that cycle.
  - LOAD → DONE when `words_written` reaches `WORD_COUNT`.
  - DONE → LOAD on `load_start` (reload). `load_start` is ignored while in LOAD.
- **Output states:**
  - `cpu_hold` = `busy` = (state == LOAD).
  - `done` = (state == DONE). `done` stays high until the next `load_start`.
- **Bytes outside LOAD:** valid bytes received in IDLE or DONE are discarded. No write is issued and the counters are unchanged.
- **Address range:** `ram_addr` never exceeds `WORD_COUNT-1`. There is no wrap-around within a load.

## Timing
- **Reset values:** every output resets to 0 (`ram_w_en`, `ram_addr`, `ram_wdata`, `cpu_hold`, `busy`, `done`, `frame_error`, `words_written`). The loader FSM resets to IDLE, the receiver FSM to RX_IDLE, and the byte phase to high.
- **Reset mid-load:** all outputs clear asynchronously and any partial word is lost. `cpu_hold` drops immediately, so RAM contents are partial; software must reload.
- **Byte latency:** a byte is valid 1 cycle after its stop-bit sample. The stop-bit sample occurs ≈ 9.5×`CLKS_PER_BIT` + 2 sync cycles after the start edge.
- **Write timing:** `ram_w_en` rises on the cycle after the low byte is valid. `ram_addr` and `ram_wdata` are stable during that cycle. The RAM captures on that cycle's rising edge.
- **Final word:** `busy`/`cpu_hold` fall and `done` rises on the cycle after the final write strobe. The core is therefore released only after the final write has completed.
- **Simultaneous events:**
  - `load_start` in the same cycle as a valid byte while in IDLE: the state change wins and that byte is discarded.
  - A frame error on a low byte: no write is issued and `words_written` is unchanged.
- **Back-to-back frames:** frames with zero idle bits between them (stop bit immediately followed by a start edge) must be received without loss.

## Test plan
Bench parameters: `CLKS_PER_BIT=4`, `WORD_COUNT=4`.
- **Reset:** `reset`=0 mid-frame → all outputs 0 within the same cycle; after release, FSMs are in IDLE/RX_IDLE.
- **Full load:** pulse `load_start`, send 0x12 0x34 0xAB 0xCD 0x00 0x01 0xFF 0xFE → four single-cycle writes: addr 0=0x1234, 1=0xABCD, 2=0x0001, 3=0xFFFE. Then `done`=1, `cpu_hold`=0, `words_written`=4.
- **Frame error:** in LOAD, send 0x12, then a frame with stop bit 0, then 0x56 0x78 → `frame_error`=1, no write from the bad frame; next write is addr 0 = 0x5678.
- **Rejected inputs:** a 1-cycle low glitch on `rx` → no byte received. Bytes 0x11 0x22 sent in IDLE → no `ram_w_en`.
- **Load_start handling:** `load_start` pulsed during LOAD after 2 words → ignored, load completes at 4 words. `load_start` in DONE → reload from addr 0, `done` clears.
- **Back-to-back bytes:** 8 bytes with zero idle bits between frames → all 4 words written correctly.
